// File: rtl/bcd_pkg.sv
// Shared constants for the BCD to binary converter.
// FSM encodings, iteration depth and digit correction values.
package bcd_pkg;

    localparam logic [2:0] IDLE  = 3'b001;
    localparam logic [2:0] SHIFT = 3'b010;
    localparam logic [2:0] DONE  = 3'b100;

    localparam int         SHIFT_DEPTH = 16;
    localparam logic [3:0] DIGIT_MAX   = 4'd9;
    localparam logic [3:0] ADJ_THRESH  = 4'd8;
    localparam logic [3:0] ADJ_VAL     = 4'd3;

    function automatic logic digit_bad(input logic [3:0] d);
        return d > DIGIT_MAX;
    endfunction

endpackage

// File: rtl/bcd_to_binary_if.sv
// Request/result bundle between the keypad path and the converter.
// master drives the digits and request; slave returns the result.
interface bcd_to_binary_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  tran_en;
    logic [3:0]            thou_data;
    logic [3:0]            hund_data;
    logic [3:0]            tens_data;
    logic [3:0]            unit_data;
    logic                  busy;
    logic                  tran_done;
    logic                  data_err;
    logic [DATA_WIDTH-1:0] bin_data;

    modport master (
        output tran_en, thou_data, hund_data, tens_data, unit_data,
        input  busy, tran_done, data_err, bin_data
    );

    modport slave (
        input  tran_en, thou_data, hund_data, tens_data, unit_data,
        output busy, tran_done, data_err, bin_data
    );
endinterface

// File: rtl/bcd_digit_adj.sv
// One BCD digit correction step of the reverse double-dabble.
// Digits of 8 or more after a right shift lose 3.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // subtract-3 correction, no borrow out of the digit
    always_comb begin
        dout = din;
        if (din >= ADJ_THRESH)
            dout = din - ADJ_VAL;
    end

endmodule

// File: rtl/bcd_to_binary.sv
// Four-digit packed BCD to binary converter, one bit per cycle.
// IDLE captures, SHIFT runs 16 iterations, DONE publishes the result.
module bcd_to_binary
    import bcd_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst,
    bcd_to_binary_if.slave bus
);

    logic [2:0]            state;
    logic [15:0]           bcd_q;
    logic [15:0]           bin_q;
    logic [4:0]            shift_cnt;
    logic                  err_q;
    logic                  done_q;
    logic                  derr_q;
    logic [DATA_WIDTH-1:0] out_q;

    logic [31:0]           shifted;
    logic [15:0]           bcd_adj;

    assign shifted = {bcd_q, bin_q} >> 1;

    for (genvar g = 0; g < 4; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (shifted[16 + 4*g +: 4]),
            .dout (bcd_adj[4*g +: 4])
        );
    end

    assign bus.busy      = (state != IDLE);
    assign bus.tran_done = done_q;
    assign bus.data_err  = derr_q;
    assign bus.bin_data  = out_q;

    // conversion FSM, datapath registers and result holding
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bcd_q     <= '0;
            bin_q     <= '0;
            shift_cnt <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            derr_q    <= 1'b0;
            out_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.tran_en) begin
                        bcd_q     <= {bus.thou_data, bus.hund_data,
                                      bus.tens_data, bus.unit_data};
                        bin_q     <= '0;
                        shift_cnt <= '0;
                        err_q     <= digit_bad(bus.thou_data) |
                                     digit_bad(bus.hund_data) |
                                     digit_bad(bus.tens_data) |
                                     digit_bad(bus.unit_data);
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_q     <= bcd_adj;
                    bin_q     <= shifted[15:0];
                    shift_cnt <= shift_cnt + 5'd1;
                    if (shift_cnt == 5'(SHIFT_DEPTH - 1))
                        state <= DONE;
                end
                DONE: begin
                    out_q  <= err_q ? '0 : bin_q[DATA_WIDTH-1:0];
                    derr_q <= err_q;
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_binary.sv
// Randomised self-checking bench for bcd_to_binary.
// Reference is plain decimal arithmetic on the digits.
module tb_bcd_to_binary;

    logic clk;
    logic rst;
    int   tests;
    int   failed;
    int   cyc;

    bcd_to_binary_if #(.DATA_WIDTH(16)) bus ();

    bcd_to_binary #(.DATA_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // free-running cycle count for inter-result spacing
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            failed++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int ref_val(input int t, h, d, u);
        if (t > 9 || h > 9 || d > 9 || u > 9)
            return 0;
        return 1000*t + 100*h + 10*d + u;
    endfunction

    function automatic int ref_err(input int t, h, d, u);
        return (t > 9 || h > 9 || d > 9 || u > 9) ? 1 : 0;
    endfunction

    // request a conversion, wait for tran_done (bounded)
    task automatic conv(input int t, h, d, u,
                        output int lat, output int bcnt, output int tdone);
        int n;
        bus.thou_data = 4'(t);
        bus.hund_data = 4'(h);
        bus.tens_data = 4'(d);
        bus.unit_data = 4'(u);
        bus.tran_en   = 1'b1;
        lat  = -1;
        bcnt = 0;
        tdone = -1;
        @(negedge clk);
        bus.tran_en = 1'b0;
        n = 1;
        forever begin
            if (bus.busy) bcnt++;
            if (bus.tran_done) begin
                lat = n - 1;
                tdone = cyc;
                break;
            end
            if (n >= 40) begin
                chk("done_timeout", 0, 1);
                break;
            end
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_check(input string tag, input int t, h, d, u);
        int lat, bcnt, td;
        conv(t, h, d, u, lat, bcnt, td);
        chk({tag, "_val"}, int'(bus.bin_data), ref_val(t, h, d, u));
        chk({tag, "_err"}, int'(bus.data_err), ref_err(t, h, d, u));
    endtask

    initial begin
        int lat, bcnt, td1, td2, cnt;
        int t, h, d, u;
        tests  = 0;
        failed = 0;
        cyc    = 0;
        rst    = 1'b1;
        bus.tran_en   = 1'b0;
        bus.thou_data = 4'd0;
        bus.hund_data = 4'd0;
        bus.tens_data = 4'd0;
        bus.unit_data = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.tran_done), 0);
        chk("rst_err", int'(bus.data_err), 0);
        chk("rst_bin", int'(bus.bin_data), 0);
        rst = 1'b0;
        @(negedge clk);

        // max value, latency and busy width
        conv(9, 9, 9, 9, lat, bcnt, td1);
        chk("9999_val", int'(bus.bin_data), 'h270F);
        chk("9999_err", int'(bus.data_err), 0);
        chk("9999_lat", lat, 17);
        chk("9999_busy", bcnt, 17);
        @(negedge clk);
        chk("done_clear", int'(bus.tran_done), 0);
        chk("hold_val", int'(bus.bin_data), 'h270F);

        run_check("1234", 1, 2, 3, 4);
        chk("1234_hex", int'(bus.bin_data), 'h04D2);
        run_check("0000", 0, 0, 0, 0);
        run_check("0008", 0, 0, 0, 8);

        // invalid digit then recovery
        run_check("00A5", 0, 0, 10, 5);
        chk("00A5_flag", int'(bus.data_err), 1);
        @(negedge clk);
        chk("err_hold", int'(bus.data_err), 1);
        run_check("0042", 0, 0, 4, 2);
        chk("0042_hex", int'(bus.bin_data), 'h002A);

        // request while busy is ignored
        bus.thou_data = 4'd5;
        bus.hund_data = 4'd6;
        bus.tens_data = 4'd7;
        bus.unit_data = 4'd8;
        bus.tran_en   = 1'b1;
        @(negedge clk);
        bus.tran_en = 1'b0;
        repeat (4) @(negedge clk);
        bus.thou_data = 4'd1;
        bus.hund_data = 4'd1;
        bus.tens_data = 4'd1;
        bus.unit_data = 4'd1;
        bus.tran_en   = 1'b1;
        @(negedge clk);
        bus.tran_en = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.tran_done) begin
                cnt++;
                chk("busy_req_val", int'(bus.bin_data), 'h162E);
            end
            @(negedge clk);
        end
        chk("busy_req_ndone", cnt, 1);

        // reset in the middle of shifting
        bus.thou_data = 4'd3;
        bus.hund_data = 4'd3;
        bus.tens_data = 4'd3;
        bus.unit_data = 4'd3;
        bus.tran_en   = 1'b1;
        @(negedge clk);
        bus.tran_en = 1'b0;
        repeat (7) @(negedge clk);
        chk("pre_rst_busy", int'(bus.busy), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", int'(bus.busy), 0);
        chk("mid_rst_bin", int'(bus.bin_data), 0);
        chk("mid_rst_done", int'(bus.tran_done), 0);
        chk("mid_rst_err", int'(bus.data_err), 0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 25; i++) begin
            if (bus.tran_done) cnt++;
            @(negedge clk);
        end
        chk("abort_no_done", cnt, 0);
        run_check("0010", 0, 0, 1, 0);

        // back-to-back restart on the done cycle
        conv(4, 3, 2, 1, lat, bcnt, td1);
        chk("b2b_first", int'(bus.bin_data), 4321);
        conv(0, 2, 5, 5, lat, bcnt, td2);
        chk("b2b_val", int'(bus.bin_data), 'h00FF);
        chk("b2b_gap", td2 - td1, 18);

        // random sweep, some with invalid digits
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                t = $urandom_range(0, 15);
                h = $urandom_range(0, 15);
                d = $urandom_range(0, 15);
                u = $urandom_range(0, 15);
            end else begin
                t = $urandom_range(0, 9);
                h = $urandom_range(0, 9);
                d = $urandom_range(0, 9);
                u = $urandom_range(0, 9);
            end
            run_check("rand", t, h, d, u);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
